// File: rtl/csr_trap_file.sv
// Machine/supervisor CSR file with trap entry, delegation, MRET/SRET, mcycle and interrupt arbitration.
// priv state | U=2'b00 user, S=2'b01 supervisor, M=2'b11 machine
module csr_trap_file #(
  parameter int XLEN = 64,
  parameter bit HAS_SMODE = 1'b1,
  parameter logic [XLEN-1:0] DELEG_MASK = XLEN'(64'h0000_0000_0000_b3ff),
  parameter logic [XLEN-1:0] IDELEG_MASK = XLEN'(64'h0000_0000_0000_0222),
  parameter bit MTVEC_VECTORED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            sret,
  input  logic            irq_mtip,
  input  logic            irq_msip,
  input  logic            irq_meip,
  input  logic            irq_take,
  output logic            irq_pending,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv,
  output logic [XLEN-1:0] satp_o,
  output logic [XLEN-1:0] mstatus_o
);

  typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11} priv_e;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MSTATUS_M = XLEN'(64'h0000_0000_007e_79bb);
  localparam logic [XLEN-1:0] SSTATUS_M = XLEN'(64'h8000_0003_0001_e122);
  localparam logic [XLEN-1:0] MIP_M     = XLEN'(64'h333);
  localparam logic [XLEN-1:0] MIE_M     = XLEN'(64'haaa);
  localparam logic [XLEN-1:0] TVEC_M    = ~XLEN'(2);
  localparam logic [XLEN-1:0] MED_M     = HAS_SMODE ? DELEG_MASK : '0;
  localparam logic [XLEN-1:0] MID_M     = HAS_SMODE ? IDELEG_MASK : '0;

  priv_e           priv_q, priv_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d, medeleg_q, medeleg_d, mideleg_q, mideleg_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mip_sw_q, mip_sw_d, mcycle_q, mcycle_d;
  logic [XLEN-1:0] stvec_q, stvec_d, sscratch_q, sscratch_d, sepc_q, sepc_d;
  logic [XLEN-1:0] scause_q, scause_d, stval_q, stval_d, satp_q, satp_d;
  logic            redir_v_q, redir_v_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic [XLEN-1:0] mip_rd, rdata, wval, irq_vec, irq_cause, cause, tval, tvec, trap_target;
  logic [3:0]      irq_code;
  logic [CW-1:0]   code;
  logic            impl, wr_req, csr_we, take_irq, trap_evt, is_int, deleg, mret_ok, sret_ok;

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] o, input logic [XLEN-1:0] v,
                                            input logic [XLEN-1:0] m);
    return (o & ~m) | (v & m);
  endfunction

  always_comb begin
    mip_rd = mip_sw_q;
    mip_rd[11] = irq_meip;
    mip_rd[7] = irq_mtip;
    mip_rd[3] = irq_msip;
  end

  always_comb begin
    rdata = '0;
    impl = 1'b1;
    case (csr_addr)
      12'h300: rdata = mstatus_q;
      12'h302: rdata = medeleg_q;
      12'h303: rdata = mideleg_q;
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = mip_rd;
      12'hB00: rdata = mcycle_q;
      12'hF14: rdata = '0;
      12'h100: rdata = mstatus_q & SSTATUS_M;
      12'h104: rdata = mie_q & mideleg_q;
      12'h105: rdata = stvec_q;
      12'h140: rdata = sscratch_q;
      12'h141: rdata = sepc_q;
      12'h142: rdata = scause_q;
      12'h143: rdata = stval_q;
      12'h144: rdata = mip_rd & mideleg_q;
      12'h180: rdata = satp_q;
      default: impl = 1'b0;
    endcase
    if (!HAS_SMODE && csr_addr[9:8] == 2'b01) begin
      rdata = '0;
      impl = 1'b0;
    end
  end

  // RS/RC with a zero operand is a pure read and may target read-only CSRs.
  assign wr_req = (csr_op == 2'b01) || ((csr_op[1] == 1'b1) && (|csr_wdata));
  assign csr_illegal = !impl || (csr_addr[9:8] > priv_q) || (csr_addr[11:10] == 2'b11 && wr_req);
  assign csr_rdata = rdata;
  assign csr_we = csr_valid && wr_req && !csr_illegal;

  always_comb begin
    case (csr_op)
      2'b10:   wval = rdata | csr_wdata;
      2'b11:   wval = rdata & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
  end

  assign irq_vec = mip_rd & mie_q & ~mideleg_q;
  assign irq_pending = (|irq_vec) && (priv_q != PRIV_M || mstatus_q[3]);

  always_comb begin
    irq_code = 4'd7;
    if (irq_vec[11])     irq_code = 4'd11;
    else if (irq_vec[3]) irq_code = 4'd3;
    else if (irq_vec[7]) irq_code = 4'd7;
    else if (irq_vec[9]) irq_code = 4'd9;
    else if (irq_vec[1]) irq_code = 4'd1;
    else if (irq_vec[5]) irq_code = 4'd5;
  end

  assign irq_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};
  assign take_irq = irq_take && irq_pending;
  assign trap_evt = trap_valid || take_irq;
  assign cause = trap_valid ? trap_cause : irq_cause;
  assign tval = trap_valid ? trap_tval : '0;
  assign is_int = cause[XLEN-1];
  assign code = cause[CW-1:0];
  assign deleg = HAS_SMODE && (priv_q != PRIV_M) && (is_int ? mideleg_q[code] : medeleg_q[code]);
  assign tvec = deleg ? stvec_q : mtvec_q;
  assign trap_target = (MTVEC_VECTORED && is_int && tvec[0])
                     ? (tvec & ~XLEN'(3)) + {{(XLEN-CW-2){1'b0}}, code, 2'b00}
                     : (tvec & ~XLEN'(3));
  assign mret_ok = mret && (priv_q == PRIV_M);
  assign sret_ok = sret && HAS_SMODE && (priv_q != PRIV_U);

  always_comb begin
    priv_d = priv_q;
    mstatus_d = mstatus_q;   medeleg_d = medeleg_q;   mideleg_d = mideleg_q;
    mie_d = mie_q;           mtvec_d = mtvec_q;       mscratch_d = mscratch_q;
    mepc_d = mepc_q;         mcause_d = mcause_q;     mtval_d = mtval_q;
    mip_sw_d = mip_sw_q;     mcycle_d = mcycle_q + XLEN'(1);
    stvec_d = stvec_q;       sscratch_d = sscratch_q; sepc_d = sepc_q;
    scause_d = scause_q;     stval_d = stval_q;       satp_d = satp_q;
    redir_v_d = 1'b0;        redir_pc_d = redir_pc_q;
    if (trap_evt) begin
      redir_v_d = 1'b1;
      redir_pc_d = trap_target;
      if (deleg) begin
        sepc_d = trap_pc;  scause_d = cause;  stval_d = tval;
        mstatus_d[5] = mstatus_q[1];
        mstatus_d[1] = 1'b0;
        mstatus_d[8] = priv_q[0];
        priv_d = PRIV_S;
      end else begin
        mepc_d = trap_pc;  mcause_d = cause;  mtval_d = tval;
        mstatus_d[7] = mstatus_q[3];
        mstatus_d[3] = 1'b0;
        mstatus_d[12:11] = priv_q;
        priv_d = PRIV_M;
      end
    end else if (mret_ok) begin
      priv_d = priv_e'(mstatus_q[12:11]);
      mstatus_d[3] = mstatus_q[7];
      mstatus_d[7] = 1'b1;
      mstatus_d[12:11] = 2'b00;
      redir_v_d = 1'b1;
      redir_pc_d = mepc_q;
    end else if (sret_ok) begin
      priv_d = priv_e'({1'b0, mstatus_q[8]});
      mstatus_d[1] = mstatus_q[5];
      mstatus_d[5] = 1'b1;
      mstatus_d[8] = 1'b0;
      redir_v_d = 1'b1;
      redir_pc_d = sepc_q;
    end else if (csr_we) begin
      case (csr_addr)
        12'h300: mstatus_d = merge(mstatus_q, wval, MSTATUS_M);
        12'h302: medeleg_d = merge(medeleg_q, wval, MED_M);
        12'h303: mideleg_d = merge(mideleg_q, wval, MID_M);
        12'h304: mie_d = merge(mie_q, wval, MIE_M);
        12'h305: mtvec_d = merge(mtvec_q, wval, TVEC_M);
        12'h340: mscratch_d = wval;
        12'h341: mepc_d = wval;
        12'h342: mcause_d = wval;
        12'h343: mtval_d = wval;
        12'h344: mip_sw_d = merge(mip_sw_q, wval, MIP_M);
        12'hB00: mcycle_d = wval;
        12'h100: mstatus_d = merge(mstatus_q, wval, SSTATUS_M);
        12'h104: mie_d = merge(mie_q, wval, mideleg_q & MIE_M);
        12'h105: stvec_d = merge(stvec_q, wval, TVEC_M);
        12'h140: sscratch_d = wval;
        12'h141: sepc_d = wval;
        12'h142: scause_d = wval;
        12'h143: stval_d = wval;
        12'h144: mip_sw_d = merge(mip_sw_q, wval, mideleg_q & MIP_M);
        12'h180: satp_d = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      priv_q <= PRIV_M;
      mstatus_q <= '0;   medeleg_q <= '0;   mideleg_q <= '0;
      mie_q <= '0;       mtvec_q <= '0;     mscratch_q <= '0;
      mepc_q <= '0;      mcause_q <= '0;    mtval_q <= '0;
      mip_sw_q <= '0;    mcycle_q <= '0;
      stvec_q <= '0;     sscratch_q <= '0;  sepc_q <= '0;
      scause_q <= '0;    stval_q <= '0;     satp_q <= '0;
      redir_v_q <= 1'b0; redir_pc_q <= '0;
    end else begin
      priv_q <= priv_d;
      mstatus_q <= mstatus_d;   medeleg_q <= medeleg_d;   mideleg_q <= mideleg_d;
      mie_q <= mie_d;           mtvec_q <= mtvec_d;       mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;         mcause_q <= mcause_d;     mtval_q <= mtval_d;
      mip_sw_q <= mip_sw_d;     mcycle_q <= mcycle_d;
      stvec_q <= stvec_d;       sscratch_q <= sscratch_d; sepc_q <= sepc_d;
      scause_q <= scause_d;     stval_q <= stval_d;       satp_q <= satp_d;
      redir_v_q <= redir_v_d;   redir_pc_q <= redir_pc_d;
    end
  end

  assign redirect_valid = redir_v_q;
  assign redirect_pc = redir_pc_q;
  assign priv = priv_q;
  assign satp_o = satp_q;
  assign mstatus_o = mstatus_q;

endmodule

// File: tb/tb_csr_trap_file.sv
// Scoreboard bench for csr_trap_file: directed stimulus queues expectations, a negedge monitor checks them.
module tb_csr_trap_file;
  logic        clk = 1'b0, reset = 1'b1;
  logic        csr_valid = 0, trap_valid = 0, mret = 0, sret = 0;
  logic        irq_mtip = 0, irq_msip = 0, irq_meip = 0, irq_take = 0;
  logic [1:0]  csr_op = 0;
  logic [11:0] csr_addr = 0;
  logic [63:0] csr_wdata = 0, trap_cause = 0, trap_tval = 0, trap_pc = 0;
  logic [63:0] csr_rdata, redirect_pc, satp_o, mstatus_o;
  logic        csr_illegal, irq_pending, redirect_valid;
  logic [1:0]  priv;

  always #5 clk = ~clk;

  csr_trap_file dut (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_tval(trap_tval), .trap_pc(trap_pc),
    .mret(mret), .sret(sret), .irq_mtip(irq_mtip), .irq_msip(irq_msip), .irq_meip(irq_meip),
    .irq_take(irq_take), .irq_pending(irq_pending), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .priv(priv), .satp_o(satp_o), .mstatus_o(mstatus_o)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        ill;
    logic [1:0]  pv;
    logic        pend;
  } probe_t;

  probe_t      probe_q[$];
  string       probe_n[$];
  logic [63:0] redir_q[$];
  string       redir_n[$];
  logic        rd_strobe = 0, done = 0;
  int          n_tests = 0, n_fail = 0;

  always @(negedge clk) begin
    probe_t      exp_p, got_p;
    logic [63:0] exp_pc;
    string       nm;
    if (redirect_valid) begin
      n_tests++;
      if (redir_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_redirect got pc=%h", redirect_pc);
      end else begin
        exp_pc = redir_q.pop_front();
        nm = redir_n.pop_front();
        if (redirect_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL %s redirect_pc got=%h exp=%h", nm, redirect_pc, exp_pc);
        end
      end
    end
    if (rd_strobe) begin
      n_tests++;
      got_p = '{csr_rdata, csr_illegal, priv, irq_pending};
      if (probe_q.size() == 0) begin
        n_fail++;
        $display("FAIL probe_underflow got rdata=%h", csr_rdata);
      end else begin
        exp_p = probe_q.pop_front();
        nm = probe_n.pop_front();
        if (got_p !== exp_p) begin
          n_fail++;
          $display("FAIL %s got rdata=%h ill=%b priv=%b pend=%b exp rdata=%h ill=%b priv=%b pend=%b",
                   nm, got_p.rdata, got_p.ill, got_p.pv, got_p.pend,
                   exp_p.rdata, exp_p.ill, exp_p.pv, exp_p.pend);
        end
      end
    end
    if (done) begin
      n_tests++;
      if (redir_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_redirects got=%0d left exp=0", redir_q.size());
      end
      n_tests++;
      if (probe_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_probes got=%0d left exp=0", probe_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] ev, input logic ill,
                    input logic [1:0] pv, input logic pd, input string nm);
    csr_valid = 0; csr_op = 0; csr_addr = a; rd_strobe = 1;
    probe_q.push_back('{ev, ill, pv, pd});
    probe_n.push_back(nm);
    tick;
    rd_strobe = 0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd,
                     input logic [63:0] ev, input logic ill, input logic [1:0] pv,
                     input logic pd, input string nm);
    csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = wd; rd_strobe = 1;
    probe_q.push_back('{ev, ill, pv, pd});
    probe_n.push_back(nm);
    tick;
    csr_valid = 0; csr_op = 0; rd_strobe = 0;
  endtask

  task automatic trap(input logic [63:0] c, input logic [63:0] pc, input logic expect_redir,
                      input logic [63:0] tgt, input string nm);
    trap_valid = 1; trap_cause = c; trap_pc = pc; trap_tval = 64'h0;
    if (expect_redir) begin
      redir_q.push_back(tgt);
      redir_n.push_back(nm);
    end
    tick;
    trap_valid = 0;
  endtask

  task automatic take_irq(input logic [63:0] pc, input logic [63:0] tgt, input string nm);
    irq_take = 1; trap_pc = pc;
    redir_q.push_back(tgt);
    redir_n.push_back(nm);
    tick;
    irq_take = 0;
  endtask

  task automatic do_ret(input logic is_m, input logic [63:0] tgt, input string nm);
    if (is_m) mret = 1;
    else sret = 1;
    redir_q.push_back(tgt);
    redir_n.push_back(nm);
    tick;
    mret = 0; sret = 0;
  endtask

  initial begin
    tick; tick;
    reset = 0;
    rd(12'hB00, 64'd0, 0, 2'b11, 0, "reset_mcycle");
    repeat (4) tick;
    rd(12'hB00, 64'd5, 0, 2'b11, 0, "mcycle_plus5");
    rd(12'h300, 64'h0, 0, 2'b11, 0, "reset_mstatus");

    csr(2'b10, 12'h300, '1, 64'h0, 0, 2'b11, 0, "mstatus_rs_old");
    rd(12'h300, 64'h7e79bb, 0, 2'b11, 0, "mstatus_mask");
    csr(2'b11, 12'h300, 64'h8, 64'h7e79bb, 0, 2'b11, 0, "mstatus_rc_old");
    rd(12'h300, 64'h7e79b3, 0, 2'b11, 0, "mstatus_mie_clr");

    csr(2'b01, 12'h302, 64'h100, 64'h0, 0, 2'b11, 0, "medeleg_wr");
    csr(2'b01, 12'h305, 64'h8000_1001, 64'h0, 0, 2'b11, 0, "mtvec_wr");
    csr(2'b01, 12'h105, 64'h8000_2000, 64'h0, 0, 2'b11, 0, "stvec_wr");
    csr(2'b01, 12'h341, 64'h8000_0100, 64'h0, 0, 2'b11, 0, "mepc_wr");
    csr(2'b01, 12'h300, 64'h0, 64'h7e79b3, 0, 2'b11, 0, "mstatus_mpp_u");
    rd(12'h302, 64'h100, 0, 2'b11, 0, "medeleg_rd");
    do_ret(1, 64'h8000_0100, "mret_to_u");
    rd(12'h300, 64'h80, 1, 2'b00, 0, "mstatus_after_mret");

    trap(64'd8, 64'h8000_0010, 1, 64'h8000_2000, "deleg_trap");
    rd(12'h141, 64'h8000_0010, 0, 2'b01, 0, "sepc");
    rd(12'h142, 64'd8, 0, 2'b01, 0, "scause");
    rd(12'h100, 64'h0, 0, 2'b01, 0, "sstatus_spp0");

    do_ret(0, 64'h8000_0010, "sret_to_u");
    csr(2'b01, 12'h300, 64'h8, 64'ha0, 1, 2'b00, 0, "u_write_mstatus");
    rd(12'h300, 64'ha0, 1, 2'b00, 0, "mstatus_unchanged");

    trap(64'd2, 64'h8000_0020, 1, 64'h8000_1000, "trap_to_m");
    rd(12'h342, 64'd2, 0, 2'b11, 0, "mcause_exc");
    rd(12'h341, 64'h8000_0020, 0, 2'b11, 0, "mepc_exc");
    csr(2'b10, 12'hF14, 64'h0, 64'h0, 0, 2'b11, 0, "mhartid_rs0");
    csr(2'b01, 12'hF14, 64'h5, 64'h0, 1, 2'b11, 0, "mhartid_rw");
    rd(12'h7C0, 64'h0, 1, 2'b11, 0, "unimpl_csr");

    csr(2'b10, 12'h300, 64'h8, 64'h20, 0, 2'b11, 0, "mie_set");
    csr(2'b01, 12'h304, 64'h80, 64'h0, 0, 2'b11, 0, "mie_mtie");
    irq_mtip = 1;
    rd(12'h344, 64'h80, 0, 2'b11, 1, "mip_mtip");
    take_irq(64'h8000_0030, 64'h8000_101c, "irq_mti_vec");
    rd(12'h342, 64'h8000_0000_0000_0007, 0, 2'b11, 0, "mcause_mti");
    rd(12'h300, 64'h18a0, 0, 2'b11, 0, "mstatus_irq");
    csr(2'b10, 12'h300, 64'h8, 64'h18a0, 0, 2'b11, 0, "mie_set2");
    csr(2'b01, 12'h304, 64'h888, 64'h80, 0, 2'b11, 1, "mie_all");
    irq_meip = 1;
    take_irq(64'h8000_0040, 64'h8000_102c, "irq_mei_prio");
    rd(12'h342, 64'h8000_0000_0000_000b, 0, 2'b11, 0, "mcause_mei");
    irq_mtip = 0; irq_meip = 0;

    csr_valid = 1; csr_op = 2'b01; csr_addr = 12'hB00; csr_wdata = 64'd100;
    tick;
    csr_valid = 0; csr_op = 0;
    rd(12'hB00, 64'd100, 0, 2'b11, 0, "mcycle_written");
    rd(12'hB00, 64'd101, 0, 2'b11, 0, "mcycle_next");
    csr_valid = 1; csr_op = 2'b01; csr_addr = 12'hB00; csr_wdata = 64'd1000; rd_strobe = 1;
    probe_q.push_back('{64'd102, 1'b0, 2'b11, 1'b0});
    probe_n.push_back("mcycle_before_trap");
    trap(64'd2, 64'h8000_0050, 1, 64'h8000_1000, "trap_beats_write");
    csr_valid = 0; csr_op = 0; rd_strobe = 0;
    rd(12'hB00, 64'd103, 0, 2'b11, 0, "mcycle_write_dropped");

    trap(64'd2, 64'h8000_0060, 0, 64'h0, "trap_then_reset");
    reset = 1;
    tick; tick;
    reset = 0;
    rd(12'hB00, 64'd0, 0, 2'b11, 0, "rst2_mcycle");
    rd(12'h300, 64'h0, 0, 2'b11, 0, "rst2_mstatus");
    rd(12'h341, 64'h0, 0, 2'b11, 0, "rst2_mepc");
    tick;
    done = 1;
  end
endmodule
